// File: rtl/int_exe_cluster_pkg.sv
// Shared pipeline definitions for the integer execution cluster.
// Holds the ALU and MDU opcode encodings, the MDU FSM state encoding and
// the commit-beat record carried from an execution unit to the ROB.
package int_exe_cluster_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLT   = 4'd2,
    ALU_SLTU  = 4'd3,
    ALU_AND   = 4'd4,
    ALU_OR    = 4'd5,
    ALU_XOR   = 4'd6,
    ALU_NOR   = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_PASS1 = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    MDU_MUL   = 3'd0,
    MDU_MULH  = 3'd1,
    MDU_MULHU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MOD   = 3'd5,
    MDU_MODU  = 3'd6
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  // Commit beat at the cluster's default widths (XLEN 32, 6-bit ROB tag).
  localparam int BEAT_XLEN  = 32;
  localparam int BEAT_TAG_W = 6;

  typedef struct packed {
    logic [BEAT_TAG_W-1:0] tag;
    logic [BEAT_XLEN-1:0]  data;
  } cmt_beat_t;

endpackage

// File: rtl/int_alu_lane.sv
// One single-cycle ALU lane with a single commit output register.
// Ports: clk/a_rst (async active-high), flush; issue side valid/op/src0/
// src1/tag/ready; commit side cmt_valid/cmt_data/cmt_tag/cmt_ready.
//
// Handshake: a beat moves when valid and ready are both high at a rising
// clk edge; valid never depends on ready, and a held commit beat keeps its
// data and tag stable until cmt_ready takes it.
module int_alu_lane
  import int_exe_cluster_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             flush,
  input  logic             valid,
  input  logic [3:0]       op,
  input  logic [XLEN-1:0]  src0,
  input  logic [XLEN-1:0]  src1,
  input  logic [TAG_W-1:0] tag,
  output logic             ready,
  output logic             cmt_valid,
  output logic [XLEN-1:0]  cmt_data,
  output logic [TAG_W-1:0] cmt_tag,
  input  logic             cmt_ready
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] result;
  logic            accept;

  assign shamt  = src1[SHW-1:0];
  // The output register can be refilled in the same cycle it drains.
  assign ready  = !flush && (!cmt_valid || cmt_ready);
  assign accept = valid && ready;

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:   result = src0 + src1;
      ALU_SUB:   result = src0 - src1;
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(src0) < $signed(src1))};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (src0 < src1)};
      ALU_AND:   result = src0 & src1;
      ALU_OR:    result = src0 | src1;
      ALU_XOR:   result = src0 ^ src1;
      ALU_NOR:   result = ~(src0 | src1);
      ALU_SLL:   result = src0 << shamt;
      ALU_SRL:   result = src0 >> shamt;
      ALU_SRA:   result = $unsigned($signed(src0) >>> shamt);
      ALU_PASS1: result = src1;
      default:   result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      cmt_valid <= 1'b0;
      cmt_data  <= '0;
      cmt_tag   <= '0;
    end else if (flush) begin
      cmt_valid <= 1'b0;
    end else if (accept) begin
      cmt_valid <= 1'b1;
      cmt_data  <= result;
      cmt_tag   <= tag;
    end else if (cmt_ready) begin
      cmt_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/int_exe_cluster.sv
// Integer execution cluster: NUM_ALU independent single-cycle ALU lanes
// plus one multi-cycle multiply/divide unit (MDU), each with its own
// commit port. flush_i kills all in-flight work.
// Ports: clk, a_rst (async active-high), flush_i; per-lane alu_* issue and
// alu_cmt_* commit arrays; mdu_* issue and mdu_cmt_* commit; mdu_state
// exposes the MDU FSM state for observation.
module int_exe_cluster
  import int_exe_cluster_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NUM_ALU   = 2,
  parameter int ROB_IDX_W = 6,
  parameter int MUL_LAT   = 2
) (
  input  logic                 clk,
  input  logic                 a_rst,
  input  logic                 flush_i,
  input  logic [NUM_ALU-1:0]   alu_valid_i,
  input  logic [3:0]           alu_op_i        [NUM_ALU],
  input  logic [XLEN-1:0]      alu_src0_i      [NUM_ALU],
  input  logic [XLEN-1:0]      alu_src1_i      [NUM_ALU],
  input  logic [ROB_IDX_W-1:0] alu_tag_i       [NUM_ALU],
  output logic [NUM_ALU-1:0]   alu_ready_o,
  output logic [NUM_ALU-1:0]   alu_cmt_valid_o,
  output logic [XLEN-1:0]      alu_cmt_data_o  [NUM_ALU],
  output logic [ROB_IDX_W-1:0] alu_cmt_tag_o   [NUM_ALU],
  input  logic [NUM_ALU-1:0]   alu_cmt_ready_i,
  input  logic                 mdu_valid_i,
  input  logic [2:0]           mdu_op_i,
  input  logic [XLEN-1:0]      mdu_src0_i,
  input  logic [XLEN-1:0]      mdu_src1_i,
  input  logic [ROB_IDX_W-1:0] mdu_tag_i,
  output logic                 mdu_ready_o,
  output logic                 mdu_cmt_valid_o,
  output logic [XLEN-1:0]      mdu_cmt_data_o,
  output logic [ROB_IDX_W-1:0] mdu_cmt_tag_o,
  input  logic                 mdu_cmt_ready_i,
  output mdu_state_e           mdu_state
);

  for (genvar g = 0; g < NUM_ALU; g++) begin : g_lane
    int_alu_lane #(.XLEN(XLEN), .TAG_W(ROB_IDX_W)) u_lane (
      .clk       (clk),
      .a_rst     (a_rst),
      .flush     (flush_i),
      .valid     (alu_valid_i[g]),
      .op        (alu_op_i[g]),
      .src0      (alu_src0_i[g]),
      .src1      (alu_src1_i[g]),
      .tag       (alu_tag_i[g]),
      .ready     (alu_ready_o[g]),
      .cmt_valid (alu_cmt_valid_o[g]),
      .cmt_data  (alu_cmt_data_o[g]),
      .cmt_tag   (alu_cmt_tag_o[g]),
      .cmt_ready (alu_cmt_ready_i[g])
    );
  end

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e          state;
  logic [CW-1:0]       cnt_q;
  logic                iter_q, is_mod_q, neg_q_q, neg_r_q;
  logic [XLEN-1:0]     quo_q, rem_q, dvs_q, res_q;
  logic [ROB_IDX_W-1:0] tag_q;

  assign mdu_state       = state;
  assign mdu_ready_o     = (state == MDU_IDLE) && !flush_i;
  assign mdu_cmt_valid_o = (state == MDU_DONE);
  assign mdu_cmt_data_o  = res_q;
  assign mdu_cmt_tag_o   = tag_q;

  // Issue-side decode: operand magnitudes, corner cases and the product.
  logic                signed_div, is_div, is_mod, a_neg, b_neg;
  logic                div_zero, div_ovf, iterate;
  logic [XLEN-1:0]     a_mag, b_mag, quick_res;
  logic [2*XLEN-1:0]   mul_a, mul_b, prod;

  always_comb begin
    signed_div = (mdu_op_i == MDU_DIV) || (mdu_op_i == MDU_MOD);
    is_div     = signed_div || (mdu_op_i == MDU_DIVU) || (mdu_op_i == MDU_MODU);
    is_mod     = (mdu_op_i == MDU_MOD) || (mdu_op_i == MDU_MODU);
    a_neg      = signed_div && mdu_src0_i[XLEN-1];
    b_neg      = signed_div && mdu_src1_i[XLEN-1];
    a_mag      = a_neg ? -mdu_src0_i : mdu_src0_i;
    b_mag      = b_neg ? -mdu_src1_i : mdu_src1_i;
    div_zero   = (mdu_src1_i == '0);
    div_ovf    = signed_div && (mdu_src0_i == XMIN) && (mdu_src1_i == '1);
    iterate    = is_div && !div_zero && !div_ovf;
    // Only MULH treats its operands as signed; MUL's low half is sign-agnostic.
    mul_a = {{XLEN{(mdu_op_i == MDU_MULH) && mdu_src0_i[XLEN-1]}}, mdu_src0_i};
    mul_b = {{XLEN{(mdu_op_i == MDU_MULH) && mdu_src1_i[XLEN-1]}}, mdu_src1_i};
    prod  = mul_a * mul_b;
    quick_res = '0;
    case (mdu_op_i)
      MDU_MUL:             quick_res = prod[XLEN-1:0];
      MDU_MULH, MDU_MULHU: quick_res = prod[2*XLEN-1:XLEN];
      default: begin
        if (is_div) begin
          if (div_zero) quick_res = is_mod ? mdu_src0_i : '1;
          else          quick_res = is_mod ? '0 : XMIN;
        end
      end
    endcase
  end

  // One restoring-division step: shift in the next dividend bit and
  // subtract the divisor when it fits. The top bit of diff is the borrow.
  logic [XLEN:0]   shifted, diff;
  logic [XLEN-1:0] quo_nx, rem_nx, q_fix, r_fix;

  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    rem_nx  = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    quo_nx  = {quo_q[XLEN-2:0], !diff[XLEN]};
    q_fix   = neg_q_q ? -quo_nx : quo_nx;
    r_fix   = neg_r_q ? -rem_nx : rem_nx;
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state    <= MDU_IDLE;
      cnt_q    <= '0;
      iter_q   <= 1'b0;
      is_mod_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      res_q    <= '0;
      tag_q    <= '0;
    end else if (flush_i) begin
      state <= MDU_IDLE;
      cnt_q <= '0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (mdu_valid_i) begin
            state    <= MDU_BUSY;
            tag_q    <= mdu_tag_i;
            res_q    <= quick_res;
            iter_q   <= iterate;
            is_mod_q <= is_mod;
            neg_q_q  <= a_neg ^ b_neg;
            neg_r_q  <= a_neg;
            quo_q    <= a_mag;
            rem_q    <= '0;
            dvs_q    <= b_mag;
            cnt_q    <= iterate ? CW'(XLEN) : (is_div ? CW'(1) : CW'(MUL_LAT));
          end
        end
        MDU_BUSY: begin
          cnt_q <= cnt_q - 1'b1;
          if (iter_q) begin
            quo_q <= quo_nx;
            rem_q <= rem_nx;
          end
          if (cnt_q == CW'(1)) begin
            state <= MDU_DONE;
            if (iter_q) res_q <= is_mod_q ? r_fix : q_fix;
          end
        end
        MDU_DONE: begin
          if (mdu_cmt_ready_i) state <= MDU_IDLE;
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_exe_cluster.sv
// Self-checking bench for int_exe_cluster at default parameters.
module tb_int_exe_cluster;
  import int_exe_cluster_pkg::*;

  localparam int XLEN    = 32;
  localparam int NUM_ALU = 2;
  localparam int TW      = 6;
  localparam int MUL_LAT = 2;
  localparam logic [31:0] XMIN = 32'h8000_0000;

  logic              clk = 1'b0;
  logic              a_rst, flush_i;
  logic [NUM_ALU-1:0] alu_valid_i, alu_ready_o, alu_cmt_valid_o, alu_cmt_ready_i;
  logic [3:0]        alu_op_i       [NUM_ALU];
  logic [XLEN-1:0]   alu_src0_i     [NUM_ALU];
  logic [XLEN-1:0]   alu_src1_i     [NUM_ALU];
  logic [TW-1:0]     alu_tag_i      [NUM_ALU];
  logic [XLEN-1:0]   alu_cmt_data_o [NUM_ALU];
  logic [TW-1:0]     alu_cmt_tag_o  [NUM_ALU];
  logic              mdu_valid_i, mdu_ready_o, mdu_cmt_valid_o, mdu_cmt_ready_i;
  logic [2:0]        mdu_op_i;
  logic [XLEN-1:0]   mdu_src0_i, mdu_src1_i, mdu_cmt_data_o;
  logic [TW-1:0]     mdu_tag_i, mdu_cmt_tag_o;
  mdu_state_e        mdu_state;

  int_exe_cluster #(.XLEN(XLEN), .NUM_ALU(NUM_ALU), .ROB_IDX_W(TW), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .a_rst(a_rst), .flush_i(flush_i),
    .alu_valid_i(alu_valid_i), .alu_op_i(alu_op_i), .alu_src0_i(alu_src0_i),
    .alu_src1_i(alu_src1_i), .alu_tag_i(alu_tag_i), .alu_ready_o(alu_ready_o),
    .alu_cmt_valid_o(alu_cmt_valid_o), .alu_cmt_data_o(alu_cmt_data_o),
    .alu_cmt_tag_o(alu_cmt_tag_o), .alu_cmt_ready_i(alu_cmt_ready_i),
    .mdu_valid_i(mdu_valid_i), .mdu_op_i(mdu_op_i), .mdu_src0_i(mdu_src0_i),
    .mdu_src1_i(mdu_src1_i), .mdu_tag_i(mdu_tag_i), .mdu_ready_o(mdu_ready_o),
    .mdu_cmt_valid_o(mdu_cmt_valid_o), .mdu_cmt_data_o(mdu_cmt_data_o),
    .mdu_cmt_tag_o(mdu_cmt_tag_o), .mdu_cmt_ready_i(mdu_cmt_ready_i),
    .mdu_state(mdu_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference functions ----------------
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic [4:0] sh;
    sa = a; sb = b; sh = b[4:0];
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd3:    return (a < b) ? 32'd1 : 32'd0;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      4'd7:    return ~(a | b);
      4'd8:    return a << sh;
      4'd9:    return a >> sh;
      4'd10:   return sa >>> sh;
      4'd11:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] mdu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic [63:0] p;
    logic ovf;
    sa = a; sb = b;
    ovf = (a == XMIN) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: return a * b;
      3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd3: if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return XMIN; else return sa / sb;
      3'd4: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      3'd5: if (b == 0) return a; else if (ovf) return 32'd0; else return sa % sb;
      3'd6: if (b == 0) return a; else return a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Busy cycles the MDU spends before showing its result.
  function automatic int mdu_busy(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd3 || op == 3'd7) return MUL_LAT;
    if (b == 0) return 1;
    if ((op == 3'd3 || op == 3'd5) && a == XMIN && b == 32'hFFFF_FFFF) return 1;
    return XLEN;
  endfunction

  // ---------------- behavioural model + compare ----------------
  cmt_beat_t exp_q [NUM_ALU][$];
  int          mdu_left;
  bit          mdu_done;
  logic [31:0] mdu_exp_data;
  logic [5:0]  mdu_exp_tag;
  bit          exp_rdy [NUM_ALU];
  bit          mdu_idle;
  cmt_beat_t   beat;

  // Outputs are compared on the falling edge; the model then steps over
  // the coming rising edge using the inputs that edge will sample.
  always @(negedge clk) begin
    if (a_rst) begin
      for (int i = 0; i < NUM_ALU; i++) begin
        exp_q[i].delete();
        check($sformatf("rst_alu_valid%0d", i), 64'(alu_cmt_valid_o[i]), 64'd0);
        check($sformatf("rst_alu_data%0d", i), 64'(alu_cmt_data_o[i]), 64'd0);
        check($sformatf("rst_alu_tag%0d", i), 64'(alu_cmt_tag_o[i]), 64'd0);
      end
      mdu_left = 0;
      mdu_done = 0;
      check("rst_mdu_valid", 64'(mdu_cmt_valid_o), 64'd0);
      check("rst_mdu_data", 64'(mdu_cmt_data_o), 64'd0);
    end else begin
      for (int i = 0; i < NUM_ALU; i++) begin
        exp_rdy[i] = !flush_i && (exp_q[i].size() == 0 || alu_cmt_ready_i[i]);
        check($sformatf("alu_ready%0d", i), 64'(alu_ready_o[i]), 64'(exp_rdy[i]));
        check($sformatf("alu_valid%0d", i), 64'(alu_cmt_valid_o[i]), 64'(exp_q[i].size() != 0));
        if (exp_q[i].size() != 0) begin
          beat = exp_q[i][0];
          check($sformatf("alu_data%0d", i), 64'(alu_cmt_data_o[i]), 64'(beat.data));
          check($sformatf("alu_tag%0d", i), 64'(alu_cmt_tag_o[i]), 64'(beat.tag));
        end
      end
      mdu_idle = (mdu_left == 0) && !mdu_done;
      check("mdu_ready", 64'(mdu_ready_o), 64'(mdu_idle && !flush_i));
      check("mdu_valid", 64'(mdu_cmt_valid_o), 64'(mdu_done));
      if (mdu_done) begin
        check("mdu_data", 64'(mdu_cmt_data_o), 64'(mdu_exp_data));
        check("mdu_tag", 64'(mdu_cmt_tag_o), 64'(mdu_exp_tag));
      end
      if (flush_i) begin
        for (int i = 0; i < NUM_ALU; i++) exp_q[i].delete();
        mdu_left = 0;
        mdu_done = 0;
      end else begin
        for (int i = 0; i < NUM_ALU; i++) begin
          if (exp_q[i].size() != 0 && alu_cmt_ready_i[i]) void'(exp_q[i].pop_front());
          if (alu_valid_i[i] && exp_rdy[i]) begin
            beat.data = alu_ref(alu_op_i[i], alu_src0_i[i], alu_src1_i[i]);
            beat.tag  = alu_tag_i[i];
            exp_q[i].push_back(beat);
          end
        end
        if (mdu_done) begin
          if (mdu_cmt_ready_i) mdu_done = 0;
        end else if (mdu_left > 0) begin
          mdu_left--;
          if (mdu_left == 0) mdu_done = 1;
        end else if (mdu_valid_i) begin
          mdu_left     = mdu_busy(mdu_op_i, mdu_src0_i, mdu_src1_i);
          mdu_exp_data = mdu_ref(mdu_op_i, mdu_src0_i, mdu_src1_i);
          mdu_exp_tag  = mdu_tag_i;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input int lane, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [5:0] tag);
    alu_valid_i[lane] = 1'b1;
    alu_op_i[lane]    = op;
    alu_src0_i[lane]  = a;
    alu_src1_i[lane]  = b;
    alu_tag_i[lane]   = tag;
  endtask

  task automatic alu_one(input string name, input int lane, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag,
                         input logic [31:0] exp);
    drive_alu(lane, op, a, b, tag);
    step();
    alu_valid_i[lane] = 1'b0;
    @(negedge clk);
    check({name, "_valid"}, 64'(alu_cmt_valid_o[lane]), 64'd1);
    check({name, "_data"}, 64'(alu_cmt_data_o[lane]), 64'(exp));
    check({name, "_tag"}, 64'(alu_cmt_tag_o[lane]), 64'(tag));
    step();
  endtask

  // Issues one MDU op from IDLE and reports the result and the cycle, counting
  // the accept cycle as 0, in which the commit beat first becomes visible.
  task automatic mdu_run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] tag, output logic [31:0] data, output int lat);
    mdu_valid_i = 1'b1;
    mdu_op_i    = op;
    mdu_src0_i  = a;
    mdu_src1_i  = b;
    mdu_tag_i   = tag;
    step();
    mdu_valid_i = 1'b0;
    lat  = -1;
    data = '0;
    for (int c = 1; c <= XLEN + 8; c++) begin
      @(negedge clk);
      if (mdu_cmt_valid_o) begin
        lat  = c;
        data = mdu_cmt_data_o;
        break;
      end
      step();
    end
    if (lat < 0) check("mdu_timeout", 64'd0, 64'd1);
    step();
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] res;
  int          lat;

  initial begin
    a_rst = 1'b1; flush_i = 1'b0;
    alu_valid_i = '0; alu_cmt_ready_i = '1;
    for (int i = 0; i < NUM_ALU; i++) begin
      alu_op_i[i] = '0; alu_src0_i[i] = '0; alu_src1_i[i] = '0; alu_tag_i[i] = '0;
    end
    mdu_valid_i = 1'b0; mdu_op_i = '0; mdu_src0_i = '0; mdu_src1_i = '0;
    mdu_tag_i = '0; mdu_cmt_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 a_rst = 1'b0;
    @(negedge clk);
    check("post_rst_alu_ready", 64'(alu_ready_o), 64'(2'b11));
    check("post_rst_mdu_ready", 64'(mdu_ready_o), 64'd1);
    step();

    // ALU directed cases
    alu_one("add_7_5", 0, ALU_ADD, 32'd7, 32'd5, 6'd3, 32'd12);
    alu_one("slt_m1_1", 1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 6'd4, 32'd1);
    alu_one("sltu_m1_1", 0, ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 6'd5, 32'd0);
    alu_one("sll", 1, ALU_SLL, 32'h0000_0003, 32'h0000_0024, 6'd6, 32'h0000_0030);
    alu_one("nor", 0, ALU_NOR, 32'h0F0F_0000, 32'h0000_00FF, 6'd7, 32'hF0F0_FF00);
    alu_one("pass1", 1, ALU_PASS1, 32'h1234_5678, 32'hCAFE_BABE, 6'd8, 32'hCAFE_BABE);
    alu_one("bad_op", 0, 4'd14, 32'h1234_5678, 32'h1, 6'd9, 32'd0);

    // SRA held under back-pressure
    drive_alu(1, ALU_SRA, 32'h8000_0000, 32'd4, 6'd10);
    alu_cmt_ready_i[1] = 1'b0;
    step();
    alu_valid_i[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("sra_hold_valid", 64'(alu_cmt_valid_o[1]), 64'd1);
      check("sra_hold_data", 64'(alu_cmt_data_o[1]), 64'hF800_0000);
      check("sra_hold_ready", 64'(alu_ready_o[1]), 64'd0);
      step();
    end
    alu_cmt_ready_i[1] = 1'b1;
    @(negedge clk);
    check("sra_drain_ready", 64'(alu_ready_o[1]), 64'd1);
    step();
    @(negedge clk);
    check("sra_drained_valid", 64'(alu_cmt_valid_o[1]), 64'd0);
    step();

    // MDU directed cases
    mdu_run(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 6'd11, res, lat);
    check("div_m7_2", 64'(res), 64'hFFFF_FFFD);
    check("div_latency", 64'(lat), 64'(XLEN + 1));
    mdu_run(MDU_MOD, 32'hFFFF_FFF9, 32'd2, 6'd12, res, lat);
    check("mod_m7_2", 64'(res), 64'hFFFF_FFFF);
    mdu_run(MDU_DIVU, 32'd5, 32'd0, 6'd13, res, lat);
    check("divu_by_zero", 64'(res), 64'hFFFF_FFFF);
    check("divu_by_zero_lat", 64'(lat), 64'd2);
    mdu_run(MDU_MODU, 32'd5, 32'd0, 6'd14, res, lat);
    check("modu_by_zero", 64'(res), 64'd5);
    mdu_run(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 6'd15, res, lat);
    check("div_ovf", 64'(res), 64'h8000_0000);
    check("div_ovf_lat", 64'(lat), 64'd2);
    mdu_run(MDU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd16, res, lat);
    check("mulh_m1_m1", 64'(res), 64'd0);
    check("mulh_lat", 64'(lat), 64'(MUL_LAT + 1));
    mdu_run(MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd17, res, lat);
    check("mulhu_max", 64'(res), 64'hFFFF_FFFE);
    mdu_run(MDU_MUL, 32'd1234, 32'd5678, 6'd18, res, lat);
    check("mul_low", 64'(res), 64'd7006652);

    // Flush during a division with ALU beats pending
    mdu_valid_i = 1'b1; mdu_op_i = MDU_DIV; mdu_src0_i = 32'd1000; mdu_src1_i = 32'd7;
    mdu_tag_i = 6'd20;
    step();
    mdu_valid_i = 1'b0;
    repeat (8) step();
    drive_alu(0, ALU_ADD, 32'd1, 32'd2, 6'd21);
    drive_alu(1, ALU_XOR, 32'hFF, 32'h0F, 6'd22);
    alu_cmt_ready_i = '0;
    step();
    flush_i = 1'b1;
    @(negedge clk);
    check("flush_alu_ready", 64'(alu_ready_o), 64'd0);
    check("flush_mdu_ready", 64'(mdu_ready_o), 64'd0);
    step();
    flush_i = 1'b0; alu_valid_i = '0; alu_cmt_ready_i = '1;
    @(negedge clk);
    check("flush_alu_valid", 64'(alu_cmt_valid_o), 64'd0);
    check("flush_mdu_valid", 64'(mdu_cmt_valid_o), 64'd0);
    check("flush_mdu_state", 64'(mdu_state), 64'(MDU_IDLE));
    check("flush_mdu_ready", 64'(mdu_ready_o), 64'd1);
    step();

    // Asynchronous reset in the middle of a division
    mdu_valid_i = 1'b1; mdu_op_i = MDU_DIVU; mdu_src0_i = 32'd12345; mdu_src1_i = 32'd3;
    mdu_tag_i = 6'd30;
    step();
    mdu_valid_i = 1'b0;
    repeat (5) step();
    #2 a_rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 a_rst = 1'b0;
    @(negedge clk);
    check("rst_mid_alu_ready", 64'(alu_ready_o), 64'(2'b11));
    check("rst_mid_mdu_ready", 64'(mdu_ready_o), 64'd1);
    repeat (40) step();
    @(negedge clk);
    check("rst_mid_no_stale", 64'(mdu_cmt_valid_o), 64'd0);
    step();

    // Randomised traffic on all units
    for (int n = 0; n < 1500; n++) begin
      flush_i = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NUM_ALU; i++) begin
        alu_valid_i[i]     = $urandom_range(0, 1) == 1;
        alu_op_i[i]        = 4'($urandom_range(0, 15));
        alu_src0_i[i]      = $urandom;
        alu_src1_i[i]      = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
        alu_tag_i[i]       = 6'($urandom_range(0, 63));
        alu_cmt_ready_i[i] = $urandom_range(0, 3) != 0;
      end
      mdu_valid_i = $urandom_range(0, 1) == 1;
      mdu_op_i    = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       mdu_src0_i = XMIN;
        1:       mdu_src0_i = 32'($urandom_range(0, 40)) - 32'd20;
        default: mdu_src0_i = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       mdu_src1_i = 32'd0;
        1:       mdu_src1_i = 32'hFFFF_FFFF;
        2:       mdu_src1_i = 32'($urandom_range(1, 9));
        default: mdu_src1_i = $urandom;
      endcase
      mdu_tag_i       = 6'($urandom_range(0, 63));
      mdu_cmt_ready_i = $urandom_range(0, 2) != 0;
      step();
    end
    flush_i = 1'b0; alu_valid_i = '0; alu_cmt_ready_i = '1;
    mdu_valid_i = 1'b0; mdu_cmt_ready_i = 1'b1;
    repeat (40) step();

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
